// File: rtl/piso.sv
// Parallel-in serial-out shifter: loads a word on a write strobe and streams it
// one bit per clock, MSB or LSB first, with an optional one-cycle zero preamble.
module piso #(
  parameter int    DATA_WIDTH   = 8,
  parameter string DO_MSB_FIRST = "true",
  parameter string DO_FAST      = "true"
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_data_valid,
  output logic                  o_data
);

  localparam bit MSB_FIRST = (DO_MSB_FIRST == "true");
  localparam bit FAST      = (DO_FAST == "true");
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    SHIFT
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // cnt holds the number of bits still to be presented after the current one
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      o_data_valid <= 1'b0;
      o_data       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wr_en) begin
            o_data_valid <= 1'b1;
            if (FAST) begin
              state  <= SHIFT;
              o_data <= head_bit(i_data);
              sreg   <= advance(i_data);
              cnt    <= CNT_W'(DATA_WIDTH - 1);
            end else begin
              state  <= PRE;
              o_data <= 1'b0;
              sreg   <= i_data;
              cnt    <= CNT_W'(DATA_WIDTH);
            end
          end
        end
        PRE: begin
          state  <= SHIFT;
          o_data <= head_bit(sreg);
          sreg   <= advance(sreg);
          cnt    <= CNT_W'(DATA_WIDTH - 1);
        end
        SHIFT: begin
          if (cnt == '0) begin
            state        <= IDLE;
            o_data_valid <= 1'b0;
            o_data       <= 1'b0;
          end else begin
            o_data <= head_bit(sreg);
            sreg   <= advance(sreg);
            cnt    <= cnt - 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          o_data_valid <= 1'b0;
          o_data       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso.sv
// Bench for piso: four instances cover every mode combination; a timing model
// derived from accept cycles predicts every output cycle, plus literal streams.
module tb_piso;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en [4];
  logic [W-1:0] din   [4];
  logic         vld   [4];
  logic         dout  [4];

  // instance order: 0 fast/msb, 1 fast/lsb, 2 slow/msb, 3 slow/lsb
  localparam bit IS_FAST [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit IS_MSB  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  piso #(.DATA_WIDTH(W), .DO_MSB_FIRST("true"), .DO_FAST("true")) u_fm (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[0]), .i_data(din[0]),
    .o_data_valid(vld[0]), .o_data(dout[0]));
  piso #(.DATA_WIDTH(W), .DO_MSB_FIRST("false"), .DO_FAST("true")) u_fl (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[1]), .i_data(din[1]),
    .o_data_valid(vld[1]), .o_data(dout[1]));
  piso #(.DATA_WIDTH(W), .DO_MSB_FIRST("true"), .DO_FAST("false")) u_sm (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[2]), .i_data(din[2]),
    .o_data_valid(vld[2]), .o_data(dout[2]));
  piso #(.DATA_WIDTH(W), .DO_MSB_FIRST("false"), .DO_FAST("false")) u_sl (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[3]), .i_data(din[3]),
    .o_data_valid(vld[3]), .o_data(dout[3]));

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: cycle index of the output slot, and the last accepted word per instance
  int           cyc         = 0;
  int           acc_cyc [4] = '{-1000, -1000, -1000, -1000};
  logic [W-1:0] acc_word[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int           acc_cnt [4] = '{0, 0, 0, 0};

  // {valid, data} expected in output slot c, from the offset since acceptance
  function automatic logic [1:0] exp_out(input int i, input int c);
    int k, j, len;
    k   = c - acc_cyc[i];
    len = W + (IS_FAST[i] ? 0 : 1);
    if (k < 0 || k >= len) return 2'b00;
    j = IS_FAST[i] ? k : k - 1;
    if (j < 0) return 2'b10;
    return {1'b1, IS_MSB[i] ? acc_word[i][W-1-j] : acc_word[i][j]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc_cyc[i] <= -1000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i] && exp_out(i, cyc) == 2'b00) begin
          acc_cyc[i]  <= cyc + 1;
          acc_word[i] <= din[i];
          acc_cnt[i]  <= acc_cnt[i] + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("stream inst%0d slot%0d", i, cyc),
            {8'b0, vld[i], dout[i]}, {8'b0, exp_out(i, cyc)});
    end
  end

  // Called at a negedge: strobe word, then record 10 output slots (oldest at bit 9).
  // Data is scrambled after the accept edge; word2 is strobed after slot poke_at.
  task automatic burst(input int idx, input logic [W-1:0] word, input logic [W-1:0] word2,
                       input int poke_at, output logic [9:0] vv, output logic [9:0] dd);
    wr_en[idx] = 1'b1;
    din[idx]   = word;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      wr_en[idx] = 1'b0;
      din[idx]   = W'($urandom);
      vv[9-s]    = vld[idx];
      dd[9-s]    = dout[idx];
      if (s == poke_at) begin
        wr_en[idx] = 1'b1;
        din[idx]   = word2;
      end
    end
    wr_en[idx] = 1'b0;
  endtask

  logic [9:0] vv, dd;
  int         base[4];
  bit         done;

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr_en[i] = 1'b0;
      din[i]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_vld%0d", i), {9'b0, vld[i]}, 10'b0);
      chk($sformatf("reset_dout%0d", i), {9'b0, dout[i]}, 10'b0);
    end
    rst = 1'b0;

    @(negedge clk);
    burst(0, 8'hC1, 8'h00, -1, vv, dd);
    chk("fast_msb_c1_vld", vv, 10'b1111111100);
    chk("fast_msb_c1_data", dd, 10'b1100000100);

    @(negedge clk);
    burst(1, 8'hC1, 8'h00, -1, vv, dd);
    chk("fast_lsb_c1_vld", vv, 10'b1111111100);
    chk("fast_lsb_c1_data", dd, 10'b1000001100);

    @(negedge clk);
    burst(2, 8'h5A, 8'h00, -1, vv, dd);
    chk("slow_msb_5a_vld", vv, 10'b1111111110);
    chk("slow_msb_5a_data", dd, 10'b0010110100);

    @(negedge clk);
    burst(3, 8'h35, 8'h00, -1, vv, dd);
    chk("slow_lsb_35_vld", vv, 10'b1111111110);
    chk("slow_lsb_35_data", dd, 10'b0101011000);

    @(negedge clk);
    burst(0, 8'hFF, 8'h00, 2, vv, dd);
    chk("busy_strobe_vld", vv, 10'b1111111100);
    chk("busy_strobe_data", dd, 10'b1111111100);

    @(negedge clk);
    burst(0, 8'h00, 8'h00, -1, vv, dd);
    chk("zero_word_vld", vv, 10'b1111111100);
    chk("zero_word_data", dd, 10'b0000000000);

    // abort at bit 4 with an asynchronous reset between clock edges
    @(negedge clk);
    wr_en[0] = 1'b1;
    din[0]   = 8'hFF;
    @(negedge clk);
    wr_en[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_vld", {8'b0, vld[0], dout[0]}, 10'b11);
    #1 rst = 1'b1;
    #1;
    chk("abort_vld", {9'b0, vld[0]}, 10'b0);
    chk("abort_dout", {9'b0, dout[0]}, 10'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    burst(0, 8'h81, 8'h00, -1, vv, dd);
    chk("post_reset_81_vld", vv, 10'b1111111100);
    chk("post_reset_81_data", dd, 10'b1000000100);

    // back-to-back random traffic on all four instances
    for (int i = 0; i < 4; i++) base[i] = acc_cnt[i];
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        wr_en[i] = ($urandom_range(0, 4) != 0);
        din[i]   = W'($urandom);
      end
      done = 1'b1;
      for (int i = 0; i < 4; i++)
        if (acc_cnt[i] - base[i] < 1000) done = 1'b0;
    end
    for (int i = 0; i < 4; i++) wr_en[i] = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL random_words: cycle budget expired before 1000 words per mode");
    end
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter DATA_WIDTH, default 8: parallel word width in bits; integer, 2 or greater.
REQ-002 Parameter DO_MSB_FIRST, default "true": "true" shifts bit DATA_WIDTH-1 first; any other string shifts bit 0 first.
REQ-003 Parameter DO_FAST, default "true": "true" selects zero-preamble timing; any other string selects one-cycle-preamble timing.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_wr_en  input  1  load strobe; a one-cycle pulse requests serialization of i_data.
REQ-007 i_data  input  DATA_WIDTH  parallel word, sampled on the rising edge where i_wr_en=1 is accepted.
REQ-008 o_data_valid  output  1  high while a transfer (preamble plus bits) is in progress.
REQ-009 o_data  output  1  serial bit stream, registered.

Function
REQ-010 The block SHALL be idle when o_data_valid=0, and SHALL accept i_wr_en=1 only when idle.
REQ-011 The block SHALL ignore i_wr_en while o_data_valid=1, including on the last bit cycle, with no effect on the current transfer.
REQ-012 On acceptance at edge E0, the block SHALL capture i_data into an internal shift register in full, with no partial loads.
REQ-013 Fast mode: o_data_valid=1 and o_data=first bit SHALL be presented from E0.
REQ-014 Fast mode: each following edge SHALL present the next bit, for exactly DATA_WIDTH bit cycles.
REQ-015 Fast mode: o_data_valid SHALL fall at E0+DATA_WIDTH.
REQ-016 Slow mode: o_data_valid SHALL rise at E0, with o_data=0 for one preamble cycle.
REQ-017 Slow mode: the first bit SHALL be presented from E0+1, for DATA_WIDTH bit cycles; o_data_valid SHALL be high for DATA_WIDTH+1 cycles and fall at E0+DATA_WIDTH+1.
REQ-018 Bit order SHALL be DATA_WIDTH-1 down to 0 when MSB-first, and 0 up to DATA_WIDTH-1 otherwise.
REQ-019 State machine: IDLE -> (slow: PRE ->) SHIFT -> IDLE; PRE lasts 1 cycle; SHIFT lasts DATA_WIDTH cycles, tracked by a bit counter of width clog2(DATA_WIDTH+1).
REQ-020 Back-to-back: a new i_wr_en SHALL be accepted on the first edge at which o_data_valid is already 0 (earliest E0+DATA_WIDTH+1 fast, E0+DATA_WIDTH+2 slow).
REQ-021 While idle, o_data SHALL be 0.
REQ-022 i_data changes outside the accept edge SHALL have no effect on a transfer.

Reset
REQ-023 While i_rst=1, and asynchronously on its assertion, the block SHALL force o_data=0, o_data_valid=0, the shift register to 0, the bit counter to 0 and the state to IDLE.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no further bits.
REQ-025 After reset release, the first i_wr_en SHALL be accepted at the next rising edge.

Verification
REQ-026 Fast, MSB-first, accept 0xC1 -> o_data 1,1,0,0,0,0,0,1 on 8 consecutive cycles from E0; o_data_valid high for exactly those 8 cycles.
REQ-027 Fast, LSB-first, accept 0xC1 -> o_data 1,0,0,0,0,0,1,1; o_data_valid high for 8 cycles.
REQ-028 Slow, MSB-first, accept 0x5A -> o_data_valid high 9 cycles; o_data 0 (preamble), then 0,1,0,1,1,0,1,0.
REQ-029 Accept 0xFF, then pulse i_wr_en with 0x00 at E0+3 -> the second strobe is ignored and the stream stays all-ones for 8 bits; a later idle strobe of 0x00 yields eight zeros.
REQ-030 Assert i_rst mid-transfer at bit 4 -> o_data_valid and o_data go 0 immediately, without waiting for a clock edge; after release an accept of 0x81 serializes correctly.
REQ-031 1000 back-to-back random words in each of the four mode combinations -> every serialized bit matches the captured word, with zero mismatches.
